// File: rtl/bcd_display.sv
// Binary-to-decimal display driver for the seven-segment bank: a sequential double-dabble
// converter with load/busy/done handshake, saturation and leading-zero blanking.
module bcd_display #(
  parameter int unsigned WIDTH  = 20,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      value,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int unsigned BIN_DIGITS = (WIDTH * 3) / 10 + 1;
  localparam int unsigned WD         = (BIN_DIGITS > DIGITS) ? BIN_DIGITS : DIGITS;
  localparam int unsigned BW         = 4 * WD;
  localparam int unsigned OW         = 4 * DIGITS;
  localparam int unsigned CW         = $clog2(WIDTH + 1);

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0]   LIMIT     = pow10(DIGITS);
  localparam logic [OW-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BW-1:0]     bcdw_q, bcdw_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovfw_q, ovfw_d;
  logic              blkw_q, blkw_d;
  logic              pend_q, pend_d;
  logic [WIDTH-1:0]  pval_q, pval_d;
  logic              pblk_q, pblk_d;
  logic [OW-1:0]     bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              blank_q, blank_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              start;
  logic [WIDTH-1:0]  start_val;
  logic              start_blk;
  logic [BW-1:0]     adj;

  // Add-3 correction applied to every working nibble before the shift
  always_comb begin
    adj = bcdw_q;
    for (int k = 0; k < int'(WD); k++) begin
      if (bcdw_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcdw_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcdw_d    = bcdw_q;
    cnt_d     = cnt_q;
    ovfw_d    = ovfw_q;
    blkw_d    = blkw_q;
    pend_d    = pend_q;
    pval_d    = pval_q;
    pblk_d    = pblk_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    blank_d   = blank_q;
    done_d    = 1'b0;
    start     = 1'b0;
    start_val = value;
    start_blk = blank_lz;

    unique case (state_q)
      S_IDLE: begin
        start = load;
      end
      S_CONV: begin
        bcdw_d = {adj[BW-2:0], bin_q[WIDTH-1]};
        bin_d  = {bin_q[WIDTH-2:0], 1'b0};
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_COMMIT;
        else                         cnt_d   = cnt_q + CW'(1);
        if (load) begin
          pend_d = 1'b1;
          pval_d = value;
          pblk_d = blank_lz;
        end
      end
      S_COMMIT: begin
        bcd_d   = ovfw_q ? ALL_NINES : bcdw_q[OW-1:0];
        ovf_d   = ovfw_q;
        blank_d = blkw_q;
        done_d  = 1'b1;
        // A load in this very cycle is the newest request and supersedes the slot
        if (load) begin
          start  = 1'b1;
          pend_d = 1'b0;
        end else if (pend_q) begin
          start     = 1'b1;
          start_val = pval_q;
          start_blk = pblk_q;
          pend_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d = S_CONV;
      bin_d   = start_val;
      bcdw_d  = '0;
      cnt_d   = '0;
      ovfw_d  = (64'(start_val) >= LIMIT);
      blkw_d  = start_blk;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcdw_q  <= '0;
      cnt_q   <= '0;
      ovfw_q  <= 1'b0;
      blkw_q  <= 1'b0;
      pend_q  <= 1'b0;
      pval_q  <= '0;
      pblk_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      blank_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcdw_q  <= bcdw_d;
      cnt_q   <= cnt_d;
      ovfw_q  <= ovfw_d;
      blkw_q  <= blkw_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      pblk_q  <= pblk_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      blank_q <= blank_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign bcd      = bcd_q;

  logic [DIGITS-1:0] blank_vec;
  logic              lz_run;

  // A display goes dark when it and every display above it hold zero; display 0 always lit
  always_comb begin
    blank_vec = '0;
    lz_run    = blank_q;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      lz_run       = lz_run && (bcd_q[4*i +: 4] == 4'd0);
      blank_vec[i] = lz_run;
    end
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_seg
    seg7 u_seg7 (
      .digit_i (bcd_q[4*g +: 4]),
      .blank_i (blank_vec[g]),
      .seg_o   (hex[7*g +: 7])
    );
  end

endmodule

// Hex digit to active-low segment pattern {g,f,e,d,c,b,a}; blank drives all segments off.
module seg7 (
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'h7f;
    if (!blank_i) begin
      unique case (digit_i)
        4'h0: seg_o = 7'h40;
        4'h1: seg_o = 7'h79;
        4'h2: seg_o = 7'h24;
        4'h3: seg_o = 7'h30;
        4'h4: seg_o = 7'h19;
        4'h5: seg_o = 7'h12;
        4'h6: seg_o = 7'h02;
        4'h7: seg_o = 7'h78;
        4'h8: seg_o = 7'h00;
        4'h9: seg_o = 7'h10;
        4'ha: seg_o = 7'h08;
        4'hb: seg_o = 7'h03;
        4'hc: seg_o = 7'h46;
        4'hd: seg_o = 7'h21;
        4'he: seg_o = 7'h06;
        4'hf: seg_o = 7'h0e;
        default: seg_o = 7'h7f;
      endcase
    end
  end
endmodule
